accel_thread_arbiter: RTL and testbench

//  Shares one header-match accelerator among NUM_THREADS requesting threads.

---
 rtl/accel_thread_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_accel_thread_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_thread_arbiter.sv
// ---------------------------------------------------------------------------
// accel_thread_arbiter
//
// Purpose:
//   Shares one 1-cycle-latency header-match accelerator among NUM_THREADS
//   requesting threads. Round-robin arbitration with one transaction in
//   flight at a time. The block sequences the accelerator start/done
//   handshake and routes the returned 4-bit action to the winning thread.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   All outputs are registered.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-low reset
//   req              per-thread request level (held until grant_ack)
//   req_header       thread i header in bits [64*i+63:64*i]
//   grant_ack        one-hot pulse; header of that thread was latched
//   resp_valid       one-hot pulse; resp_action valid for that thread
//   resp_action      action returned to the thread
//   accel_header     header driven to the accelerator (held outside ISSUE)
//   accel_start      accelerator start pulse (high only in ISSUE)
//   accel_thread_id  thread id sent with start (held outside ISSUE)
//   accel_done       accelerator done
//   accel_action     accelerator action
//   accel_tid_in     thread id returned by the accelerator
//   busy             high whenever the FSM is not in IDLE
//   timeout_err      sticky timeout flag, cleared only by reset
//
// Optional feature (macro ACCEL_ARB_STATS_EN):
//   Adds stat_grants[31:0] (+1 per ISSUE) and stat_timeouts[15:0]
//   (+1 per timeout). Both saturate at all-ones and clear on reset.
// ---------------------------------------------------------------------------
module accel_thread_arbiter #(
  parameter int NUM_THREADS    = 8,
  parameter int TID_W          = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_THREADS-1:0]    req,
  input  logic [NUM_THREADS*64-1:0] req_header,
  output logic [NUM_THREADS-1:0]    grant_ack,
  output logic [NUM_THREADS-1:0]    resp_valid,
  output logic [3:0]                resp_action,
  output logic [63:0]               accel_header,
  output logic                      accel_start,
  output logic [TID_W-1:0]          accel_thread_id,
  input  logic                      accel_done,
  input  logic [3:0]                accel_action,
  input  logic [TID_W-1:0]          accel_tid_in,
  output logic                      busy,
  output logic                      timeout_err
`ifdef ACCEL_ARB_STATS_EN
  ,
  output logic [31:0]               stat_grants,
  output logic [15:0]               stat_timeouts
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TID_W-1:0] LAST_TID  = TID_W'(NUM_THREADS - 1);

  logic [1:0]             state_q, state_d;
  logic [TID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_THREADS-1:0] grant_ack_q, grant_ack_d;
  logic [NUM_THREADS-1:0] resp_valid_q, resp_valid_d;
  logic [3:0]             resp_action_q, resp_action_d;
  logic [63:0]            accel_header_q, accel_header_d;
  logic                   accel_start_q, accel_start_d;
  logic [TID_W-1:0]       accel_thread_id_q, accel_thread_id_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
`ifdef ACCEL_ARB_STATS_EN
  logic [31:0]            stat_grants_q, stat_grants_d;
  logic [15:0]            stat_timeouts_q, stat_timeouts_d;
`endif

  // Per-thread header slices and the round-robin search order
  // (candidate k is thread (rr_ptr + k) mod NUM_THREADS).
  logic [63:0]      hdr_arr  [NUM_THREADS];
  logic [TID_W-1:0] cand_idx [NUM_THREADS];

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      assign hdr_arr[gi]  = req_header[64*gi +: 64];
      assign cand_idx[gi] = TID_W'((int'(rr_ptr_q) + gi) % NUM_THREADS);
    end
  endgenerate

  logic             win_found;
  logic [TID_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      if (!win_found && req[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // accel_thread_id_q holds the current winner for the whole transaction,
  // so it doubles as the thread the response is routed to.
  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    timer_d           = timer_q;
    grant_ack_d       = '0;
    resp_valid_d      = '0;
    resp_action_d     = resp_action_q;
    accel_header_d    = accel_header_q;
    accel_start_d     = 1'b0;
    accel_thread_id_d = accel_thread_id_q;
    timeout_err_d     = timeout_err_q;
`ifdef ACCEL_ARB_STATS_EN
    stat_grants_d     = stat_grants_q;
    stat_timeouts_d   = stat_timeouts_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d                = S_ISSUE;
          grant_ack_d[win_idx]   = 1'b1;
          accel_start_d          = 1'b1;
          accel_thread_id_d      = win_idx;
          accel_header_d         = hdr_arr[win_idx];
`ifdef ACCEL_ARB_STATS_EN
          if (stat_grants_q != '1) stat_grants_d = stat_grants_q + 32'd1;
`endif
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (accel_done && (accel_tid_in == accel_thread_id_q)) begin
          resp_action_d                   = accel_action;
          resp_valid_d[accel_thread_id_q] = 1'b1;
          state_d                         = S_RESP;
        end else begin
          // A done tagged with another thread id is a stale result and
          // counts as an idle WAIT cycle.
          timer_d = timer_q + 1'b1;
          if (timer_d == TMR_LIMIT) begin
            resp_action_d                   = 4'b0000;
            resp_valid_d[accel_thread_id_q] = 1'b1;
            timeout_err_d                   = 1'b1;
            state_d                         = S_RESP;
`ifdef ACCEL_ARB_STATS_EN
            if (stat_timeouts_q != '1) stat_timeouts_d = stat_timeouts_q + 16'd1;
`endif
          end
        end
      end
      default: begin  // S_RESP
        rr_ptr_d = (accel_thread_id_q == LAST_TID) ? '0 : accel_thread_id_q + 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      rr_ptr_q          <= '0;
      timer_q           <= '0;
      grant_ack_q       <= '0;
      resp_valid_q      <= '0;
      resp_action_q     <= '0;
      accel_header_q    <= '0;
      accel_start_q     <= 1'b0;
      accel_thread_id_q <= '0;
      busy_q            <= 1'b0;
      timeout_err_q     <= 1'b0;
`ifdef ACCEL_ARB_STATS_EN
      stat_grants_q     <= '0;
      stat_timeouts_q   <= '0;
`endif
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      timer_q           <= timer_d;
      grant_ack_q       <= grant_ack_d;
      resp_valid_q      <= resp_valid_d;
      resp_action_q     <= resp_action_d;
      accel_header_q    <= accel_header_d;
      accel_start_q     <= accel_start_d;
      accel_thread_id_q <= accel_thread_id_d;
      busy_q            <= busy_d;
      timeout_err_q     <= timeout_err_d;
`ifdef ACCEL_ARB_STATS_EN
      stat_grants_q     <= stat_grants_d;
      stat_timeouts_q   <= stat_timeouts_d;
`endif
    end
  end

  assign grant_ack       = grant_ack_q;
  assign resp_valid      = resp_valid_q;
  assign resp_action     = resp_action_q;
  assign accel_header    = accel_header_q;
  assign accel_start     = accel_start_q;
  assign accel_thread_id = accel_thread_id_q;
  assign busy            = busy_q;
  assign timeout_err     = timeout_err_q;
`ifdef ACCEL_ARB_STATS_EN
  assign stat_grants     = stat_grants_q;
  assign stat_timeouts   = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_accel_thread_arbiter.sv
// ---------------------------------------------------------------------------
// tb_accel_thread_arbiter
//
// Directed bench for accel_thread_arbiter (8 threads, 16-cycle timeout).
// Inputs change and outputs are sampled on the falling edge of clk; the
// accelerator is modelled inline by each scenario task.
// ---------------------------------------------------------------------------
module tb_accel_thread_arbiter;
  localparam int N     = 8;
  localparam int TID_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*64-1:0]  req_header;
  logic [N-1:0]     grant_ack;
  logic [N-1:0]     resp_valid;
  logic [3:0]       resp_action;
  logic [63:0]      accel_header;
  logic             accel_start;
  logic [TID_W-1:0] accel_thread_id;
  logic             accel_done;
  logic [3:0]       accel_action;
  logic [TID_W-1:0] accel_tid_in;
  logic             busy;
  logic             timeout_err;
`ifdef ACCEL_ARB_STATS_EN
  logic [31:0]      stat_grants;
  logic [15:0]      stat_timeouts;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  accel_thread_arbiter #(.NUM_THREADS(N), .TID_W(TID_W), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_header      (req_header),
    .grant_ack       (grant_ack),
    .resp_valid      (resp_valid),
    .resp_action     (resp_action),
    .accel_header    (accel_header),
    .accel_start     (accel_start),
    .accel_thread_id (accel_thread_id),
    .accel_done      (accel_done),
    .accel_action    (accel_action),
    .accel_tid_in    (accel_tid_in),
    .busy            (busy),
    .timeout_err     (timeout_err)
`ifdef ACCEL_ARB_STATS_EN
    ,
    .stat_grants     (stat_grants),
    .stat_timeouts   (stat_timeouts)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Runs one transaction from an IDLE negedge with req already driven:
  // captures the ISSUE outputs, echoes the issued tid back with action act
  // one cycle later, captures the response, and returns at the IDLE negedge.
  task automatic do_txn(input logic [3:0] act,
                        output logic [N-1:0] g, output logic [TID_W-1:0] t,
                        output logic [63:0] h, output logic s,
                        output logic [N-1:0] rv, output logic [3:0] ra);
    step();
    g = grant_ack; t = accel_thread_id; h = accel_header; s = accel_start;
    req = req & ~grant_ack;
    step();
    accel_done = 1'b1; accel_tid_in = accel_thread_id; accel_action = act;
    step();
    rv = resp_valid; ra = resp_action;
    accel_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '1; accel_done = 1'b1; accel_tid_in = '0; accel_action = 4'hF;
    step(); step(); step();
    tests_run++;
    if ({grant_ack, resp_valid, resp_action, accel_header, accel_start, accel_thread_id, busy, timeout_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got grant=%b resp=%b act=%h hdr=%h start=%b tid=%0d busy=%b terr=%b, expected all 0",
               grant_ack, resp_valid, resp_action, accel_header, accel_start, accel_thread_id, busy, timeout_err);
    end
    $display("[TB] test_reset done");
    req = '0; accel_done = 1'b0; reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    req = 8'b0000_0100;
    step();
    tests_run++;
    if (grant_ack !== 8'b0000_0100 || accel_start !== 1'b1 || accel_thread_id !== 3'd2 ||
        accel_header !== 64'h0000_C0A8_0001_0000 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_issue: got grant=%b start=%b tid=%0d hdr=%h busy=%b, expected 00000100 1 2 0000c0a800010000 1",
               grant_ack, accel_start, accel_thread_id, accel_header, busy);
    end
    req = '0;
    step();
    tests_run++;
    if (grant_ack !== '0 || accel_start !== 1'b0 || resp_valid !== '0 ||
        accel_header !== 64'h0000_C0A8_0001_0000 || accel_thread_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL single_wait: got grant=%b start=%b resp=%b hdr=%h tid=%0d, expected 0 0 0 held hdr, tid 2",
               grant_ack, accel_start, resp_valid, accel_header, accel_thread_id);
    end
    accel_done = 1'b1; accel_tid_in = 3'd2; accel_action = 4'hF;
    step();
    tests_run++;
    if (resp_valid !== 8'b0000_0100 || resp_action !== 4'hF) begin
      tests_failed++;
      $display("FAIL single_resp: got resp=%b act=%h, expected 00000100 f", resp_valid, resp_action);
    end
    accel_done = 1'b0;
    step();
    tests_run++;
    if (resp_valid !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: got resp=%b busy=%b, expected 0 0", resp_valid, busy);
    end
    $display("[TB] test_single thread 2 done");
  endtask

  task automatic test_all_requests();
    logic [N-1:0] g, rv;
    logic [TID_W-1:0] t;
    logic [63:0] h;
    logic s;
    logic [3:0] ra;
    reset = 1'b0; req = '1;
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      do_txn(4'(k + 1), g, t, h, s, rv, ra);
      tests_run++;
      if (g !== (8'b1 << k) || t !== 3'(k) || s !== 1'b1 || h !== req_header[64*k +: 64] ||
          rv !== (8'b1 << k) || ra !== 4'(k + 1)) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got grant=%b tid=%0d start=%b resp=%b act=%h, expected grant=resp=%b tid=%0d act=%h",
                 k, g, t, s, rv, ra, 8'b1 << k, k, 4'(k + 1));
      end
      $display("[TB] test_all_requests grant %0d done", k);
    end
  endtask

  task automatic test_rr_order();
    logic [N-1:0] g, rv;
    logic [TID_W-1:0] t;
    logic [63:0] h;
    logic s;
    logic [3:0] ra;
    req = 8'b0000_1000;
    do_txn(4'h3, g, t, h, s, rv, ra);
    tests_run++;
    if (g !== 8'b0000_1000 || rv !== 8'b0000_1000 || ra !== 4'h3) begin
      tests_failed++;
      $display("FAIL rr_thread3: got grant=%b resp=%b act=%h, expected 00001000 00001000 3", g, rv, ra);
    end
    req = 8'b0010_0010;
    do_txn(4'h5, g, t, h, s, rv, ra);
    tests_run++;
    if (g !== 8'b0010_0000 || t !== 3'd5 || rv !== 8'b0010_0000) begin
      tests_failed++;
      $display("FAIL rr_first_5: got grant=%b tid=%0d resp=%b, expected 00100000 5 00100000", g, t, rv);
    end
    do_txn(4'h1, g, t, h, s, rv, ra);
    tests_run++;
    if (g !== 8'b0000_0010 || t !== 3'd1 || rv !== 8'b0000_0010 || ra !== 4'h1) begin
      tests_failed++;
      $display("FAIL rr_then_1: got grant=%b tid=%0d resp=%b act=%h, expected 00000010 1 00000010 1", g, t, rv, ra);
    end
    $display("[TB] test_rr_order done");
  endtask

  task automatic test_timeout();
    req = 8'b0100_0000;
    step();
    tests_run++;
    if (grant_ack !== 8'b0100_0000 || accel_thread_id !== 3'd6) begin
      tests_failed++;
      $display("FAIL to_grant: got grant=%b tid=%0d, expected 01000000 6", grant_ack, accel_thread_id);
    end
    req = '0;
    for (int c = 0; c < 16; c++) step();
    tests_run++;
    if (resp_valid !== '0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_early: got resp=%b terr=%b busy=%b, expected 0 0 1", resp_valid, timeout_err, busy);
    end
    step();
    tests_run++;
    if (resp_valid !== 8'b0100_0000 || resp_action !== 4'h0 || timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_resp: got resp=%b act=%h terr=%b, expected 01000000 0 1", resp_valid, resp_action, timeout_err);
    end
    // Late result after the timeout must not produce a response.
    accel_done = 1'b1; accel_tid_in = 3'd6; accel_action = 4'hF;
    step();
    tests_run++;
    if (resp_valid !== '0 || resp_action !== 4'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_late_done: got resp=%b act=%h busy=%b, expected 0 0 0", resp_valid, resp_action, busy);
    end
    accel_done = 1'b0;
    step(); step();
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_sticky: got terr=%b, expected 1", timeout_err);
    end
`ifdef ACCEL_ARB_STATS_EN
    tests_run++;
    if (stat_timeouts !== 16'd1 || stat_grants !== 32'd12) begin
      tests_failed++;
      $display("FAIL to_stats: got timeouts=%0d grants=%0d, expected 1 12", stat_timeouts, stat_grants);
    end
`endif
    $display("[TB] test_timeout done");
  endtask

  task automatic test_stale_tid();
    req = 8'b0001_0000;
    step();
    tests_run++;
    if (grant_ack !== 8'b0001_0000 || accel_thread_id !== 3'd4) begin
      tests_failed++;
      $display("FAIL stale_grant: got grant=%b tid=%0d, expected 00010000 4", grant_ack, accel_thread_id);
    end
    req = '0;
    step();
    accel_done = 1'b1; accel_tid_in = 3'd6; accel_action = 4'hA;
    step();
    tests_run++;
    if (resp_valid !== '0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_ignored: got resp=%b busy=%b, expected 0 1", resp_valid, busy);
    end
    accel_tid_in = 3'd4; accel_action = 4'hF;
    step();
    tests_run++;
    if (resp_valid !== 8'b0001_0000 || resp_action !== 4'hF) begin
      tests_failed++;
      $display("FAIL stale_match: got resp=%b act=%h, expected 00010000 f", resp_valid, resp_action);
    end
    accel_done = 1'b0;
    step();
    $display("[TB] test_stale_tid done");
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] g, rv;
    logic [TID_W-1:0] t;
    logic [63:0] h;
    logic s;
    logic [3:0] ra;
    req = 8'b0010_0000;
    step();
    tests_run++;
    if (grant_ack !== 8'b0010_0000) begin
      tests_failed++;
      $display("FAIL rst_grant: got grant=%b, expected 00100000", grant_ack);
    end
    req = '0;
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if ({grant_ack, resp_valid, resp_action, accel_header, accel_start, accel_thread_id, busy, timeout_err} !== '0) begin
      tests_failed++;
      $display("FAIL rst_outputs: got grant=%b resp=%b act=%h hdr=%h start=%b tid=%0d busy=%b terr=%b, expected all 0",
               grant_ack, resp_valid, resp_action, accel_header, accel_start, accel_thread_id, busy, timeout_err);
    end
    reset = 1'b1;
    accel_done = 1'b1; accel_tid_in = 3'd5; accel_action = 4'hF;
    step();
    tests_run++;
    if (resp_valid !== '0 || busy !== 1'b0 || resp_action !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_late_done: got resp=%b busy=%b act=%h, expected 0 0 0", resp_valid, busy, resp_action);
    end
    accel_done = 1'b0;
    req = 8'b0010_0001;
    do_txn(4'h3, g, t, h, s, rv, ra);
    tests_run++;
    if (g !== 8'b0000_0001 || t !== 3'd0 || rv !== 8'b0000_0001 || ra !== 4'h3) begin
      tests_failed++;
      $display("FAIL rst_rr_from_0: got grant=%b tid=%0d resp=%b act=%h, expected 00000001 0 00000001 3", g, t, rv, ra);
    end
    req = '0;
    step(); step(); step(); step(); step();
    $display("[TB] test_reset_in_wait done");
  endtask

  initial begin
    reset = 1'b0; req = '0; accel_done = 1'b0; accel_tid_in = '0; accel_action = '0;
    for (int i = 0; i < N; i++) req_header[64*i +: 64] = 64'hA5A5_0000_1111_0000 | 64'(i);
    req_header[64*2 +: 64] = 64'h0000_C0A8_0001_0000;
    test_reset();
    test_single();
    test_all_requests();
    test_rr_order();
    test_timeout();
    test_stale_tid();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
